// File: rtl/datapath_mc_pkg.sv
// datapath_mc_pkg
// Shared definitions for the multi-cycle single-bus datapath:
//   - ALU op codes carried on uop_alu
//   - bus source codes, given as offsets above the GPR codes (0..NGPR-1)
//   - destination-mask bit offsets, given as offsets above the GPR bits
//   - control FSM state encoding
package datapath_mc_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_SHR  = 4'd4;
  localparam logic [3:0] ALU_SHRA = 4'd5;
  localparam logic [3:0] ALU_SHL  = 4'd6;
  localparam logic [3:0] ALU_ROR  = 4'd7;
  localparam logic [3:0] ALU_ROL  = 4'd8;
  localparam logic [3:0] ALU_NEG  = 4'd9;
  localparam logic [3:0] ALU_NOT  = 4'd10;
  localparam logic [3:0] ALU_MUL  = 4'd11;
  localparam logic [3:0] ALU_DIV  = 4'd12;
  localparam logic [3:0] ALU_PASS = 4'd13;

  // Source codes above the GPRs (code = NGPR + offset)
  localparam int SRC_HI     = 0;
  localparam int SRC_LO     = 1;
  localparam int SRC_ZH     = 2;
  localparam int SRC_ZL     = 3;
  localparam int SRC_PC     = 4;
  localparam int SRC_IR     = 5;
  localparam int SRC_MDR    = 6;
  localparam int SRC_INPORT = 7;
  localparam int SRC_CSIGN  = 8;

  // Destination mask bits above the GPRs (bit = NGPR + offset)
  localparam int DST_HI  = 0;
  localparam int DST_LO  = 1;
  localparam int DST_Y   = 2;
  localparam int DST_MAR = 3;
  localparam int DST_MDR = 4;
  localparam int DST_PC  = 5;
  localparam int DST_IR  = 6;
  localparam int DST_OUT = 7;
  localparam int DST_Z   = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MULDIV = 2'd1,
    ST_MEM    = 2'd2
  } state_e;

endpackage

// File: rtl/datapath_mc_seq_muldiv.sv
// seq_muldiv
// Iterative signed multiplier / divider, one radix-2 step per clock.
// Operands are reduced to magnitudes on start; signs are reapplied
// combinationally on the outputs.
// Ports:
//   clk, clr       clock, async active-high reset
//   start          capture a/b and perform the first step this edge
//   op             0 = multiply (a*b), 1 = divide (a/b)
//   a, b           signed operands
//   busy           an operation is in progress
//   done           result valid on hi/lo during this cycle
//   hi, lo         multiply: product high/low; divide: remainder/quotient
//   div0           divide by zero, valid together with done
module seq_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div0
);

  localparam int CW = $clog2(WIDTH + 1);

  logic             is_div, sa, sb, b_zero;
  logic [WIDTH-1:0] m, acc_hi, acc_lo;
  logic [CW-1:0]    cnt;

  logic             cur_div;
  logic [WIDTH-1:0] a_mag, b_mag, cur_hi, cur_lo, cur_m, nxt_hi, nxt_lo;
  logic [WIDTH:0]   sum, trial;
  logic [2*WIDTH-1:0] prod;

  // One iteration step. On the start edge the step is applied to the
  // freshly loaded operands, so WIDTH steps finish on the edge before the
  // result is consumed and done lines up with the WIDTH-th edge.
  // Multiply: accumulator {hi,lo} shifts right, adding m when lo[0] is set.
  // Divide (restoring): {rem,quo} shifts left, subtracting m when it fits.
  // With m = 0 the divide leaves quo all ones and rem = |a|.
  always_comb begin
    a_mag = a[WIDTH-1] ? -a : a;
    b_mag = b[WIDTH-1] ? -b : b;
    if (start) begin
      cur_div = op;
      cur_hi  = '0;
      cur_lo  = op ? a_mag : b_mag;
      cur_m   = op ? b_mag : a_mag;
    end else begin
      cur_div = is_div;
      cur_hi  = acc_hi;
      cur_lo  = acc_lo;
      cur_m   = m;
    end
    sum    = '0;
    trial  = '0;
    nxt_hi = cur_hi;
    nxt_lo = cur_lo;
    if (cur_div) begin
      trial  = {cur_hi, cur_lo[WIDTH-1]};
      nxt_lo = {cur_lo[WIDTH-2:0], 1'b0};
      if (trial >= {1'b0, cur_m}) begin
        trial     = trial - {1'b0, cur_m};
        nxt_lo[0] = 1'b1;
      end
      nxt_hi = trial[WIDTH-1:0];
    end else begin
      sum = {1'b0, cur_hi} + (cur_lo[0] ? {1'b0, cur_m} : '0);
      {nxt_hi, nxt_lo} = {sum, cur_lo[WIDTH-1:1]};
    end
  end

  // Operand capture and iteration counter
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      busy   <= 1'b0;
      is_div <= 1'b0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      b_zero <= 1'b0;
      m      <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      cnt    <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      is_div <= op;
      sa     <= a[WIDTH-1];
      sb     <= b[WIDTH-1];
      b_zero <= (b == '0);
      m      <= cur_m;
      acc_hi <= nxt_hi;
      acc_lo <= nxt_lo;
      cnt    <= CW'(1);
    end else if (busy) begin
      if (done) begin
        busy <= 1'b0;
      end else begin
        acc_hi <= nxt_hi;
        acc_lo <= nxt_lo;
        cnt    <= cnt + CW'(1);
      end
    end
  end

  assign done = busy && (cnt == CW'(WIDTH));
  assign div0 = done && is_div && b_zero;

  // Sign restoration: product sign is sa^sb; quotient sign is sa^sb;
  // remainder follows the dividend. Divide by zero forces an all-ones
  // quotient, and the remainder path then reproduces the dividend.
  always_comb begin
    prod = (sa ^ sb) ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    if (is_div) begin
      hi = sa ? -acc_hi : acc_hi;
      lo = b_zero ? '1 : ((sa ^ sb) ? -acc_lo : acc_lo);
    end else begin
      hi = prod[2*WIDTH-1:WIDTH];
      lo = prod[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/datapath_mc.sv
// datapath_mc
// Multi-cycle single-bus CPU datapath. One micro-op is accepted per
// uop_valid & uop_ready handshake; MUL/DIV and memory accesses stall the
// control unit by dropping uop_ready.
// Ports:
//   clk, clr                         clock, async active-high reset
//   uop_valid/uop_ready              micro-op handshake
//   uop_src, uop_ba                  bus source select, R0-reads-zero
//   uop_dst                          write mask (GPRs, HI, LO, Y, MAR, MDR, PC, IR, OUT, Z)
//   uop_alu                          ALU op for Z
//   uop_incpc, uop_rd, uop_wr        PC increment, memory read/write
//   mem_req/we/addr/wdata/ack/rdata  memory req/ack port
//   in_strobe, in_data               inport load
//   out_data                         outport register
//   bus, pc, ir, zl, zh              observation outputs
//   div0, err                        one-cycle status pulses
module datapath_mc #(
  parameter int               WIDTH    = 32,
  parameter int               NGPR     = 16,
  parameter int               IMM_W    = 19,
  parameter logic [WIDTH-1:0] PC_RESET = '0,
  localparam int              NDST     = NGPR + 9
) (
  input  logic                        clk,
  input  logic                        clr,
  input  logic                        uop_valid,
  output logic                        uop_ready,
  input  logic [$clog2(NGPR+9)-1:0]   uop_src,
  input  logic [NDST-1:0]             uop_dst,
  input  logic [3:0]                  uop_alu,
  input  logic                        uop_ba,
  input  logic                        uop_incpc,
  input  logic                        uop_rd,
  input  logic                        uop_wr,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [WIDTH-1:0]            mem_addr,
  output logic [WIDTH-1:0]            mem_wdata,
  input  logic                        mem_ack,
  input  logic [WIDTH-1:0]            mem_rdata,
  input  logic                        in_strobe,
  input  logic [WIDTH-1:0]            in_data,
  output logic [WIDTH-1:0]            out_data,
  output logic [WIDTH-1:0]            bus,
  output logic [WIDTH-1:0]            pc,
  output logic [WIDTH-1:0]            ir,
  output logic [WIDTH-1:0]            zl,
  output logic [WIDTH-1:0]            zh,
  output logic                        div0,
  output logic                        err
);
  import datapath_mc_pkg::*;

  localparam int SW  = $clog2(NGPR + 9);
  localparam int GW  = $clog2(NGPR);
  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH-1:0] gpr [NGPR];
  logic [WIDTH-1:0] hi_r, lo_r, y_r, mar_r, mdr_r, inport_r;
  logic             we_r;
  state_e           state, state_nxt;

  logic [GW-1:0]    gpr_idx;
  logic [SW-1:0]    rel;
  logic [WIDTH-1:0] csign;
  logic             accept, z_sel, is_md_op, alu_illegal, md_start, mem_go, err_now;
  logic [SHW-1:0]   sh;
  logic [SHW:0]     rsh;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH-1:0] alu_lo, alu_hi;
  logic             md_busy, md_done, md_div0;
  logic [WIDTH-1:0] md_hi, md_lo;

  assign csign = {{(WIDTH-IMM_W){ir[IMM_W-1]}}, ir[IMM_W-1:0]};

  // Shared bus: GPR codes first, then special registers; anything past
  // CSIGN reads as zero.
  always_comb begin
    bus     = '0;
    gpr_idx = uop_src[GW-1:0];
    rel     = uop_src - SW'(NGPR);
    if (uop_src < SW'(NGPR)) begin
      bus = (uop_ba && gpr_idx == '0) ? '0 : gpr[gpr_idx];
    end else begin
      case (rel)
        SW'(SRC_HI):     bus = hi_r;
        SW'(SRC_LO):     bus = lo_r;
        SW'(SRC_ZH):     bus = zh;
        SW'(SRC_ZL):     bus = zl;
        SW'(SRC_PC):     bus = pc;
        SW'(SRC_IR):     bus = ir;
        SW'(SRC_MDR):    bus = mdr_r;
        SW'(SRC_INPORT): bus = inport_r;
        SW'(SRC_CSIGN):  bus = csign;
        default:         bus = '0;
      endcase
    end
  end

  assign accept      = uop_valid && (state == ST_IDLE);
  assign z_sel       = uop_dst[NGPR+DST_Z];
  assign is_md_op    = (uop_alu == ALU_MUL) || (uop_alu == ALU_DIV);
  assign alu_illegal = z_sel && (uop_alu >= 4'd14);
  assign md_start    = accept && z_sel && is_md_op;
  // A MUL/DIV owns the stall; a memory request in the same micro-op is
  // dropped and flagged rather than silently queued.
  assign mem_go      = accept && (uop_rd ^ uop_wr) && !md_start;
  assign err_now     = accept && ((uop_rd && uop_wr) || alu_illegal ||
                                  (md_start && (uop_rd || uop_wr)));

  // Single-cycle ALU: A operand is Y, B operand is the bus.
  // Only ADD reports into ZH (carry-out); the others clear it.
  always_comb begin
    alu_lo  = '0;
    alu_hi  = '0;
    sh      = bus[SHW-1:0];
    rsh     = (SHW+1)'(WIDTH) - {1'b0, sh};
    add_sum = {1'b0, y_r} + {1'b0, bus};
    case (uop_alu)
      ALU_ADD: begin
        alu_lo = add_sum[WIDTH-1:0];
        alu_hi = WIDTH'(add_sum[WIDTH]);
      end
      ALU_SUB:  alu_lo = y_r - bus;
      ALU_AND:  alu_lo = y_r & bus;
      ALU_OR:   alu_lo = y_r | bus;
      ALU_SHR:  alu_lo = y_r >> sh;
      ALU_SHRA: alu_lo = $signed(y_r) >>> sh;
      ALU_SHL:  alu_lo = y_r << sh;
      ALU_ROR:  alu_lo = (y_r >> sh) | (y_r << rsh);
      ALU_ROL:  alu_lo = (y_r << sh) | (y_r >> rsh);
      ALU_NEG:  alu_lo = -bus;
      ALU_NOT:  alu_lo = ~bus;
      ALU_PASS: alu_lo = bus;
      default: begin
        alu_lo = '0;
        alu_hi = '0;
      end
    endcase
  end

  seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk   (clk),
    .clr   (clr),
    .start (md_start),
    .op    (uop_alu == ALU_DIV),
    .a     (y_r),
    .b     (bus),
    .busy  (md_busy),
    .done  (md_done),
    .hi    (md_hi),
    .lo    (md_lo),
    .div0  (md_div0)
  );

  // Control state register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next state and handshake outputs. mem_req is decoded from the state so
  // an async reset withdraws it immediately. Leaving MULDIV on !md_busy
  // only matters if the sequencer was somehow never started.
  always_comb begin
    state_nxt = state;
    uop_ready = 1'b0;
    mem_req   = 1'b0;
    case (state)
      ST_IDLE: begin
        uop_ready = 1'b1;
        if (md_start)    state_nxt = ST_MULDIV;
        else if (mem_go) state_nxt = ST_MEM;
      end
      ST_MULDIV: begin
        if (md_done || !md_busy) state_nxt = ST_IDLE;
      end
      ST_MEM: begin
        mem_req = 1'b1;
        if (mem_ack) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign mem_we    = mem_req && we_r;
  assign mem_addr  = mar_r;
  assign mem_wdata = mdr_r;

  // Register bank. Accept-edge writes and the later MDR/Z completions can
  // never coincide, because accepts only happen in IDLE.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < NGPR; i++) gpr[i] <= '0;
      hi_r     <= '0;
      lo_r     <= '0;
      y_r      <= '0;
      mar_r    <= '0;
      mdr_r    <= '0;
      inport_r <= '0;
      we_r     <= 1'b0;
      pc       <= PC_RESET;
      ir       <= '0;
      out_data <= '0;
      zl       <= '0;
      zh       <= '0;
      err      <= 1'b0;
      div0     <= 1'b0;
    end else begin
      err  <= err_now;
      div0 <= md_div0;
      if (in_strobe) inport_r <= in_data;
      if (accept) begin
        for (int i = 0; i < NGPR; i++) begin
          if (uop_dst[i]) gpr[i] <= bus;
        end
        if (uop_dst[NGPR+DST_HI])  hi_r     <= bus;
        if (uop_dst[NGPR+DST_LO])  lo_r     <= bus;
        if (uop_dst[NGPR+DST_Y])   y_r      <= bus;
        if (uop_dst[NGPR+DST_MAR]) mar_r    <= bus;
        if (uop_dst[NGPR+DST_MDR]) mdr_r    <= bus;
        if (uop_dst[NGPR+DST_IR])  ir       <= bus;
        if (uop_dst[NGPR+DST_OUT]) out_data <= bus;
        if (uop_dst[NGPR+DST_PC])  pc       <= bus;
        else if (uop_incpc)        pc       <= pc + WIDTH'(1);
        if (z_sel && !alu_illegal && !is_md_op) begin
          zl <= alu_lo;
          zh <= alu_hi;
        end
        we_r <= uop_wr;
      end
      if (state == ST_MEM && mem_ack && !we_r) mdr_r <= mem_rdata;
      if (md_done) begin
        zl <= md_lo;
        zh <= md_hi;
      end
    end
  end

endmodule

// File: tb/tb_datapath_mc.sv
// tb_datapath_mc
// Directed bench for datapath_mc (WIDTH=32, NGPR=16, IMM_W=19,
// PC_RESET=0x100). Source codes: R0..R15 = 0..15, HI 16, LO 17, ZH 18,
// ZL 19, PC 20, IR 21, MDR 22, INPORT 23, CSIGN 24. Mask bits: R0..R15,
// HI 16, LO 17, Y 18, MAR 19, MDR 20, PC 21, IR 22, OUT 23, Z 24.
module tb_datapath_mc;

  localparam logic [4:0]  S_R0 = 5'd0,  S_R1 = 5'd1, S_R2 = 5'd2, S_R3 = 5'd3;
  localparam logic [4:0]  S_MDR = 5'd22, S_IN = 5'd23, S_CSIGN = 5'd24;
  localparam logic [24:0] D_R0  = 25'd1 << 0;
  localparam logic [24:0] D_R1  = 25'd1 << 1;
  localparam logic [24:0] D_R2  = 25'd1 << 2;
  localparam logic [24:0] D_R3  = 25'd1 << 3;
  localparam logic [24:0] D_Y   = 25'd1 << 18;
  localparam logic [24:0] D_MAR = 25'd1 << 19;
  localparam logic [24:0] D_IR  = 25'd1 << 22;
  localparam logic [24:0] D_OUT = 25'd1 << 23;
  localparam logic [24:0] D_Z   = 25'd1 << 24;
  localparam logic [3:0]  OP_ADD = 4'd0, OP_MUL = 4'd11, OP_DIV = 4'd12, OP_BAD = 4'd14;

  logic        clk, clr;
  logic        uop_valid, uop_ready;
  logic [4:0]  uop_src;
  logic [24:0] uop_dst;
  logic [3:0]  uop_alu;
  logic        uop_ba, uop_incpc, uop_rd, uop_wr;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        in_strobe;
  logic [31:0] in_data, out_data, bus, pc, ir, zl, zh;
  logic        div0, err;

  int checks = 0;
  int failures = 0;
  int cycles, pulses;

  datapath_mc #(
    .WIDTH(32), .NGPR(16), .IMM_W(19), .PC_RESET(32'h100)
  ) dut (
    .clk(clk), .clr(clr),
    .uop_valid(uop_valid), .uop_ready(uop_ready),
    .uop_src(uop_src), .uop_dst(uop_dst), .uop_alu(uop_alu),
    .uop_ba(uop_ba), .uop_incpc(uop_incpc), .uop_rd(uop_rd), .uop_wr(uop_wr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .in_strobe(in_strobe), .in_data(in_data), .out_data(out_data),
    .bus(bus), .pc(pc), .ir(ir), .zl(zl), .zh(zh),
    .div0(div0), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Offer one micro-op for one edge, then return the inputs to idle
  task automatic applyStimulus(input logic [4:0] src, input logic [24:0] dst,
                               input logic [3:0] alu, input logic ba,
                               input logic incpc, input logic rd, input logic wr);
    uop_valid = 1'b1;
    uop_src   = src;
    uop_dst   = dst;
    uop_alu   = alu;
    uop_ba    = ba;
    uop_incpc = incpc;
    uop_rd    = rd;
    uop_wr    = wr;
    tick();
    uop_valid = 1'b0;
    uop_src   = '0;
    uop_dst   = '0;
    uop_alu   = '0;
    uop_ba    = 1'b0;
    uop_incpc = 1'b0;
    uop_rd    = 1'b0;
    uop_wr    = 1'b0;
  endtask

  task automatic strobeIn(input logic [31:0] v);
    in_strobe = 1'b1;
    in_data   = v;
    tick();
    in_strobe = 1'b0;
  endtask

  task automatic peekBus(input logic [4:0] src, input logic ba, input string tag,
                         input logic [31:0] expected);
    uop_src = src;
    uop_ba  = ba;
    #1;
    checkOutput(tag, bus, expected);
    uop_src = '0;
    uop_ba  = 1'b0;
  endtask

  // Count stalled cycles until uop_ready returns (bounded), answering a
  // memory request with ack when ack_at stalled cycles have elapsed, and
  // counting div0 pulses including one cycle past the stall.
  task automatic waitReady(input logic [31:0] rdata, input int ack_at);
    cycles = 0;
    pulses = 0;
    while (!uop_ready && cycles < 200) begin
      mem_ack   = (cycles == ack_at);
      mem_rdata = rdata;
      tick();
      cycles++;
      if (div0) pulses++;
    end
    mem_ack = 1'b0;
    tick();
    if (div0) pulses++;
  endtask

  initial begin
    clr = 1'b0; uop_valid = 1'b0; uop_src = '0; uop_dst = '0; uop_alu = '0;
    uop_ba = 1'b0; uop_incpc = 1'b0; uop_rd = 1'b0; uop_wr = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0; in_strobe = 1'b0; in_data = '0;

    $display("[TB] reset");
    #1 clr = 1'b1;
    #1;
    checkOutput("reset_pc", pc, 32'h100);
    checkOutput("reset_ready", 32'(uop_ready), 32'd1);
    checkOutput("reset_mem_req", 32'(mem_req), 32'd0);
    checkOutput("reset_out", out_data, 32'd0);
    checkOutput("reset_zl", zl, 32'd0);
    tick();
    tick();
    clr = 1'b0;

    $display("[TB] add and register moves");
    strobeIn(32'h5A);
    applyStimulus(S_IN, D_R0 | D_R1, OP_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
    strobeIn(32'h1);
    applyStimulus(S_IN, D_R2, OP_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
    peekBus(S_R0, 1'b0, "r0_plain", 32'h5A);
    peekBus(S_R0, 1'b1, "r0_ba_zero", 32'h0);
    applyStimulus(S_R1, D_Y, OP_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("single_cycle_ready", 32'(uop_ready), 32'd1);
    applyStimulus(S_R2, D_Z, OP_ADD, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("add_zl", zl, 32'h5B);
    checkOutput("add_zh", zh, 32'h0);
    checkOutput("add_ready", 32'(uop_ready), 32'd1);
    checkOutput("incpc", pc, 32'h101);
    applyStimulus(S_R2, D_OUT, OP_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("outport", out_data, 32'h1);

    $display("[TB] add carry");
    strobeIn(32'hFFFF_FFFF);
    applyStimulus(S_IN, D_Y, OP_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(S_R2, D_Z, OP_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("carry_zl", zl, 32'h0);
    checkOutput("carry_zh", zh, 32'h1);

    $display("[TB] signed multiply");
    strobeIn(32'h2);
    applyStimulus(S_IN, D_Z, OP_MUL, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("mul_busy", 32'(uop_ready), 32'd0);
    waitReady(32'h0, -1);
    checkOutput("mul_cycles", 32'(cycles), 32'd32);
    checkOutput("mul_zh", zh, 32'hFFFF_FFFF);
    checkOutput("mul_zl", zl, 32'hFFFF_FFFE);

    $display("[TB] divide by zero");
    strobeIn(32'h7);
    applyStimulus(S_IN, D_Y, OP_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(S_R0, D_Z, OP_DIV, 1'b1, 1'b0, 1'b0, 1'b0);
    waitReady(32'h0, -1);
    checkOutput("div0_cycles", 32'(cycles), 32'd32);
    checkOutput("div0_zl", zl, 32'hFFFF_FFFF);
    checkOutput("div0_zh", zh, 32'h7);
    checkOutput("div0_pulses", 32'(pulses), 32'd1);

    $display("[TB] signed divide");
    strobeIn(32'hFFFF_FFF9);
    applyStimulus(S_IN, D_Y, OP_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
    strobeIn(32'h2);
    applyStimulus(S_IN, D_Z, OP_DIV, 1'b0, 1'b0, 1'b0, 1'b0);
    waitReady(32'h0, -1);
    checkOutput("div_zl", zl, 32'hFFFF_FFFD);
    checkOutput("div_zh", zh, 32'hFFFF_FFFF);
    checkOutput("div_no_div0", 32'(pulses), 32'd0);

    $display("[TB] illegal alu op");
    applyStimulus(S_IN, D_Z, OP_BAD, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("bad_alu_err", 32'(err), 32'd1);
    checkOutput("bad_alu_zl_hold", zl, 32'hFFFF_FFFD);
    checkOutput("bad_alu_zh_hold", zh, 32'hFFFF_FFFF);
    tick();
    checkOutput("bad_alu_err_clear", 32'(err), 32'd0);

    $display("[TB] IR and immediate");
    strobeIn(32'h0004_0005);
    applyStimulus(S_IN, D_IR, OP_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("ir_load", ir, 32'h0004_0005);
    peekBus(S_CSIGN, 1'b0, "csign", 32'hFFFC_0005);

    $display("[TB] memory read");
    strobeIn(32'h40);
    applyStimulus(S_IN, D_MAR, OP_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(S_R0, '0, OP_ADD, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("rd_req", 32'(mem_req), 32'd1);
    checkOutput("rd_addr", mem_addr, 32'h40);
    checkOutput("rd_we", 32'(mem_we), 32'd0);
    waitReady(32'hCAFE_BABE, 3);
    checkOutput("rd_stall", 32'(cycles), 32'd4);
    checkOutput("rd_req_drop", 32'(mem_req), 32'd0);
    peekBus(S_MDR, 1'b0, "rd_mdr", 32'hCAFE_BABE);

    $display("[TB] memory write, immediate ack");
    applyStimulus(S_R0, '0, OP_ADD, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("wr_we", 32'(mem_we), 32'd1);
    checkOutput("wr_data", mem_wdata, 32'hCAFE_BABE);
    waitReady(32'h0, 0);
    checkOutput("wr_stall", 32'(cycles), 32'd1);
    peekBus(S_MDR, 1'b0, "wr_mdr_keep", 32'hCAFE_BABE);

    $display("[TB] stray ack and rd+wr");
    mem_ack = 1'b1;
    mem_rdata = 32'h1234_5678;
    tick();
    mem_ack = 1'b0;
    checkOutput("stray_ack_ready", 32'(uop_ready), 32'd1);
    peekBus(S_MDR, 1'b0, "stray_ack_mdr", 32'hCAFE_BABE);
    applyStimulus(S_IN, D_R3, OP_ADD, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("rdwr_err", 32'(err), 32'd1);
    checkOutput("rdwr_no_req", 32'(mem_req), 32'd0);
    checkOutput("rdwr_ready", 32'(uop_ready), 32'd1);
    peekBus(S_R3, 1'b0, "rdwr_reg_write", 32'h40);

    $display("[TB] reset during multiply");
    strobeIn(32'h3);
    applyStimulus(S_IN, D_Z, OP_MUL, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (9) tick();
    checkOutput("mid_mul_busy", 32'(uop_ready), 32'd0);
    clr = 1'b1;
    #1;
    checkOutput("mid_mul_ready", 32'(uop_ready), 32'd1);
    checkOutput("mid_mul_zl", zl, 32'h0);
    checkOutput("mid_mul_zh", zh, 32'h0);
    checkOutput("mid_mul_pc", pc, 32'h100);
    #2 clr = 1'b0;
    tick();
    checkOutput("mid_mul_idle", 32'(uop_ready), 32'd1);

    $display("[TB] reset during memory");
    applyStimulus(S_R0, '0, OP_ADD, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("mid_mem_req", 32'(mem_req), 32'd1);
    clr = 1'b1;
    #1;
    checkOutput("mid_mem_req_drop", 32'(mem_req), 32'd0);
    #1 clr = 1'b0;
    tick();
    checkOutput("mid_mem_idle", 32'(uop_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/datapath_mc.md
# datapath_mc

Parametrised, multi-cycle successor to the single-bus CPU datapath. It executes one micro-op per handshake from the control unit and holds the GPR bank, HI/LO, Y, Z (high/low), PC, IR, MAR, MDR, inport and outport registers around one shared bus. Multiply and divide run iteratively. Memory access uses a req/ack handshake, so latency is variable and the control unit must stall on `uop_ready`.

## Interface
- `WIDTH`, 32: datapath width.
- `NGPR`, 16: number of general-purpose registers; must be a power of two, at least 2.
- `IMM_W`, 19: immediate field width, taken from IR[IMM_W-1:0] and sign-extended to WIDTH.
- `PC_RESET`, 0: PC value after reset.
- `NDST`: localparam, equal to NGPR+9.
- `clk` in 1: single clock; all state changes on the rising edge.
- `clr` in 1: reset; asynchronous, active-high.
- `uop_valid` in 1: micro-op offered.
- `uop_ready` out 1: block can accept a micro-op.
- `uop_src` in $clog2(NGPR+9): bus source code.
- `uop_dst` in NDST: destination write mask. Bits [NGPR-1:0] are GPRs; then, in order: HI, LO, Y, MAR, MDR, PC, IR, OUTPORT, Z.
- `uop_alu` in 4: ALU op code; used when the Z bit is set.
- `uop_ba` in 1: R0 reads as 0 on the bus.
- `uop_incpc`, `uop_rd`, `uop_wr` in 1: PC+1, memory read, memory write.
- `mem_req` out 1, `mem_we` out 1, `mem_addr` out WIDTH, `mem_wdata` out WIDTH: memory request. `mem_addr` is MAR; `mem_wdata` is MDR.
- `mem_ack` in 1, `mem_rdata` in WIDTH: memory response.
- `in_strobe` in 1, `in_data` in WIDTH: inport load.
- `out_data` out WIDTH: outport register.
- `bus` out WIDTH, `pc` out WIDTH, `ir` out WIDTH, `zl` out WIDTH, `zh` out WIDTH: observation outputs.
- `div0` out 1: one-cycle pulse on divide by zero.
- `err` out 1: one-cycle pulse on an illegal micro-op.

## Operation
- **Source codes:** 0..NGPR-1 select GPRs, then HI, LO, ZH, ZL, PC, IR, MDR, INPORT, CSIGN.
  - An unused code drives 0 on the bus.
  - R0 drives 0 when `uop_ba`=1.
- **States:** IDLE, MULDIV, MEM. `uop_ready`=1 only in IDLE.
- **Accept:** a micro-op is accepted on an edge with `uop_valid & uop_ready`. On that edge:
  - Every masked register loads `bus`.
  - Z loads ALU(Y, bus) when the Z bit is set.
  - PC loads PC+1 if `uop_incpc`=1. A PC bit in the mask overrides `uop_incpc`.
- **ALU ops:** 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SHR, 5 SHRA, 6 SHL, 7 ROR, 8 ROL, 9 NEG, 10 NOT, 11 MUL, 12 DIV, 13 PASS; 14–15 are illegal.
  - Shift amount is bus[$clog2(WIDTH)-1:0].
  - Single-cycle ops write ZL; ZH is cleared, except ADD, which writes carry-out into ZH[0].
- **MUL / DIV:** both are signed, multiply giving 2·WIDTH bits. On accept, operands Y and bus are captured and the block enters MULDIV for WIDTH cycles.
  - MUL result: ZH:ZL = product.
  - DIV result: ZL = quotient, ZH = remainder, remainder sign following the dividend.
  - Divisor 0: ZL = all ones, ZH = dividend, `div0` pulses on the completion edge.
- **Memory:** `uop_rd` or `uop_wr` moves the block to MEM.
  - `mem_req` is held until `mem_ack`.
  - Read: MDR loads `mem_rdata` on the ack edge, overriding any MDR bit in the mask.
  - After ack the block returns to IDLE.
  - MAR/MDR masked in the same micro-op are written on the accept edge; the request uses the new values.
- **Illegal micro-ops:**
  - `uop_rd` and `uop_wr` both set: `err` pulses, no memory access, register writes still occur.
  - ALU op 14–15 with the Z bit set: `err` pulses, Z holds.
- **Inport:** `in_strobe` loads `in_data` into the inport register in any state.
- **Outport:** `out_data` loads from the bus when the OUTPORT bit is set.
- **Reset:**
  - All registers go to 0, except PC, which goes to PC_RESET.
  - State returns to IDLE; `mem_req`, `div0`, `err` = 0; `uop_ready` = 1.
  - An in-flight MUL/DIV or memory request is abandoned immediately, without waiting for a clock.

## Timing
- **Single-cycle micro-op:** 1 cycle. Back-to-back accepts are allowed; `uop_ready` stays high.
- **MUL/DIV:** `uop_ready` is low for exactly WIDTH cycles after the accept edge. Z is valid, and `uop_ready`=1, on the cycle after the WIDTH-th edge.
- **Memory:** `mem_req` rises in the cycle after accept. With ack N cycles after req rises, `uop_ready` is low for N+1 cycles; an ack in the first req cycle gives N=0.
- `mem_ack` outside MEM is ignored.
- `bus` is combinational from `uop_src` and `uop_ba` in every state.

## Structure
- **Package `datapath_mc_pkg`:** ALU op codes, source codes relative to NGPR, destination bit offsets, state enum.
- **Sub-module `seq_muldiv`:**
  - Parameter WIDTH.
  - Inputs: start, op, a, b.
  - Outputs: busy, done, hi, lo, div0.
  - Radix-2 shift-add multiply and restoring divide.
- Register bank, ALU and FSM are inline.

## Test plan
- **Reset:** assert `clr` with PC_RESET=0x100 → `pc`=0x100, `uop_ready`=1, `mem_req`=0, `out_data`=0.
- **Add:** inport strobe 0x5A → R1, 0x1 → R2; Y←R1; src R2 with Z, ADD → `zl`=0x5B, `zh`=0, one cycle per micro-op.
- **Signed multiply:** Y=0xFFFFFFFF, bus=2, MUL → ZH:ZL = 0xFFFFFFFF_FFFFFFFE; `uop_ready` low exactly 32 cycles.
- **Divide:** DIV 7/0 → `zl`=0xFFFFFFFF, `zh`=7, one `div0` pulse. DIV −7/2 → `zl`=−3, `zh`=−1.
- **Memory read:** MAR=0x40, `uop_rd`, ack 3 cycles after req → MDR = `mem_rdata`, `uop_ready` low 4 cycles. `uop_rd` and `uop_wr` together → `err` pulse, no `mem_req`.
- **Reset mid-operation:** `clr` in cycle 10 of a MUL → `uop_ready`=1 before the next edge, `zl`=`zh`=0. `clr` during MEM → `mem_req`=0 asynchronously.
